uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx.sv | 70 +++++++
 rtl/uart.sv | 78 +++++++
 tb/tb_uart.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and parity type shared by the uart receiver and transmitter
package uart_pkg;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic {PAR_EVEN, PAR_ODD} parity_e;
    localparam parity_e PARITY_TYPE = PAR_EVEN;
    localparam logic PARITY_INV = (PARITY_TYPE == PAR_ODD);
endpackage

// File: rtl/uart_rx.sv
// uart_rx: one-sample-per-bit frame receiver with parity check and completion pulse
module uart_rx import uart_pkg::*; #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_i,
    output logic [W-1:0] data_o,
    output logic         parity_err_o,
    output logic         flag_o
);
    localparam int CW = W > 1 ? $clog2(W) : 1;
    rx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] sh_q, sh_d, data_q, data_d;
    logic par_q, par_d, perr_q, perr_d, flag_q, flag_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            flag_q  <= flag_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        par_d   = par_q;
        perr_d  = perr_q;
        flag_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d   = '0;
                state_d = serial_i ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                sh_d    = W'({serial_i, sh_q} >> 1);
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(W - 1)) ? RX_PARITY : RX_DATA;
            end
            RX_PARITY: begin
                par_d   = serial_i;
                state_d = RX_STOP;
            end
            default: begin
                // stop bit value is deliberately not checked
                data_d  = sh_q;
                perr_d  = par_q ^ (^sh_q) ^ PARITY_INV;
                flag_d  = 1'b1;
                state_d = RX_IDLE;
            end
        endcase
    end
    assign data_o       = data_q;
    assign parity_err_o = perr_q;
    assign flag_o       = flag_q;
endmodule

// File: rtl/uart.sv
// uart: one-clock-per-bit UART with even parity; receiver in uart_rx, transmitter FSM here
module uart import uart_pkg::*; #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Serial_In,
    input  logic [WORD_LENGTH-1:0] Parallel_In,
    input  logic                   Transmit,
    output logic                   Parity_Error,
    output logic [WORD_LENGTH-1:0] Parallel_Out,
    output logic                   Serial_Out,
    output logic                   Flag_Rx
);
    localparam int CW = WORD_LENGTH > 1 ? $clog2(WORD_LENGTH) : 1;
    tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WORD_LENGTH-1:0] sh_q, sh_d;
    logic par_q, par_d, out_q, out_d;

    uart_rx #(.W(WORD_LENGTH)) u_rx (
        .clk          (Clk),
        .rst          (Reset),
        .serial_i     (Serial_In),
        .data_o       (Parallel_Out),
        .parity_err_o (Parity_Error),
        .flag_o       (Flag_Rx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            out_q   <= out_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        out_d   = out_q;
        case (state_q)
            TX_START: begin
                out_d   = sh_q[0];
                sh_d    = sh_q >> 1;
                cnt_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: begin
                out_d   = (cnt_q == CW'(WORD_LENGTH - 1)) ? par_q : sh_q[0];
                sh_d    = sh_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WORD_LENGTH - 1)) ? TX_PARITY : TX_DATA;
            end
            TX_PARITY: begin
                out_d   = 1'b1;
                state_d = TX_STOP;
            end
            default: begin
                // the stop edge doubles as an idle edge so held Transmit gives back-to-back frames
                sh_d    = Transmit ? Parallel_In : sh_q;
                par_d   = Transmit ? (^Parallel_In) ^ PARITY_INV : par_q;
                out_d   = !Transmit;
                state_d = Transmit ? TX_START : TX_IDLE;
            end
        endcase
    end
    assign Serial_Out = out_q;
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed self-checking bench for the uart (RX, TX, reset abort, loopback)
module tb_uart;
    localparam int W = 8;
    logic Clk = 1'b0, Reset = 1'b1, si = 1'b1, loop = 1'b0, Transmit = 1'b0;
    logic [W-1:0] Parallel_In = '0;
    logic [W-1:0] Parallel_Out;
    logic Serial_In, Serial_Out, Parity_Error, Flag_Rx;
    logic [10:0] exp_bits;
    int n_chk = 0, n_fail = 0, flag_cnt = 0, f0 = 0;

    assign Serial_In = loop ? Serial_Out : si;
    always #5 Clk = ~Clk;
    always @(negedge Clk) if (Flag_Rx) flag_cnt++;

    uart #(.WORD_LENGTH(W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Serial_In    (Serial_In),
        .Parallel_In  (Parallel_In),
        .Transmit     (Transmit),
        .Parity_Error (Parity_Error),
        .Parallel_Out (Parallel_Out),
        .Serial_Out   (Serial_Out),
        .Flag_Rx      (Flag_Rx)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // leaves the bench just after the stop-bit edge
    task automatic rx_frame(input logic [7:0] d, input logic p, input logic s);
        si = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            si = d[i];
            tick;
        end
        si = p;
        tick;
        chk1("rx_flag_early", Flag_Rx, 1'b0);
        si = s;
        tick;
    endtask

    initial begin
        tick;
        tick;
        chk1("rst_sout", Serial_Out, 1'b1);
        chk8("rst_pout", Parallel_Out, 8'h00);
        chk1("rst_perr", Parity_Error, 1'b0);
        chk1("rst_flag", Flag_Rx, 1'b0);
        Reset = 1'b0;
        tick;
        tick;

        f0 = flag_cnt;
        rx_frame(8'h09, 1'b0, 1'b1);
        chk1("good_flag", Flag_Rx, 1'b1);
        chk8("good_pout", Parallel_Out, 8'h09);
        chk1("good_perr", Parity_Error, 1'b0);
        si = 1'b1;
        tick;
        chk1("good_flag_end", Flag_Rx, 1'b0);
        chk8("good_hold", Parallel_Out, 8'h09);
        chki("good_pulses", flag_cnt - f0, 1);

        rx_frame(8'h7E, 1'b1, 1'b1);
        chk1("perr_flag", Flag_Rx, 1'b1);
        chk8("perr_pout", Parallel_Out, 8'h7E);
        chk1("perr_perr", Parity_Error, 1'b1);
        si = 1'b1;
        tick;
        tick;
        chk1("perr_hold", Parity_Error, 1'b1);

        rx_frame(8'h81, 1'b0, 1'b0);
        si = 1'b1;
        chk1("stop0_flag", Flag_Rx, 1'b1);
        chk8("stop0_pout", Parallel_Out, 8'h81);
        chk1("stop0_perr", Parity_Error, 1'b0);
        tick;
        chk1("stop0_flag_end", Flag_Rx, 1'b0);
        tick;

        f0 = flag_cnt;
        rx_frame(8'h5A, 1'b0, 1'b1);
        chk8("b2b_first", Parallel_Out, 8'h5A);
        rx_frame(8'h3C, 1'b0, 1'b1);
        chk8("b2b_second", Parallel_Out, 8'h3C);
        si = 1'b1;
        tick;
        chki("b2b_pulses", flag_cnt - f0, 2);

        Parallel_In = 8'h09;
        Transmit = 1'b1;
        tick;
        Transmit = 1'b0;
        exp_bits = {1'b1, 1'b0, 8'h09, 1'b0};
        for (int i = 0; i < 11; i++) begin
            chk1($sformatf("tx_bit%0d", i), Serial_Out, exp_bits[i]);
            if (i == 3) begin
                Transmit = 1'b1;
                Parallel_In = 8'hFF;
            end
            if (i == 4) Transmit = 1'b0;
            tick;
        end
        chk1("tx_idle0", Serial_Out, 1'b1);
        tick;
        chk1("tx_idle1", Serial_Out, 1'b1);

        Parallel_In = 8'h03;
        Transmit = 1'b1;
        tick;
        exp_bits = {1'b1, 1'b0, 8'h03, 1'b0};
        for (int i = 0; i < 11; i++) begin
            chk1($sformatf("txb_bit%0d", i), Serial_Out, exp_bits[i]);
            tick;
        end
        chk1("txb_start2", Serial_Out, 1'b0);
        Transmit = 1'b0;
        Parallel_In = 8'h00;
        tick;
        chk1("txb_d0_2", Serial_Out, 1'b1);
        repeat (10) tick;
        chk1("txb_idle", Serial_Out, 1'b1);

        f0 = flag_cnt;
        si = 1'b0;
        Transmit = 1'b1;
        tick;
        Transmit = 1'b0;
        si = 1'b1;
        tick;
        si = 1'b0;
        tick;
        Reset = 1'b1;
        tick;
        chk1("rstmid_flag", Flag_Rx, 1'b0);
        chk8("rstmid_pout", Parallel_Out, 8'h00);
        chk1("rstmid_perr", Parity_Error, 1'b0);
        chk1("rstmid_sout", Serial_Out, 1'b1);
        Reset = 1'b0;
        si = 1'b1;
        repeat (14) tick;
        chki("rstmid_pulses", flag_cnt - f0, 0);
        chk8("rstmid_pout_after", Parallel_Out, 8'h00);
        chk1("rstmid_sout_after", Serial_Out, 1'b1);

        loop = 1'b1;
        f0 = flag_cnt;
        Parallel_In = 8'hA5;
        Transmit = 1'b1;
        tick;
        Transmit = 1'b0;
        for (int i = 0; i < 20 && !Flag_Rx; i++) tick;
        chk1("lb_flag", Flag_Rx, 1'b1);
        chk8("lb_pout", Parallel_Out, 8'hA5);
        chk1("lb_perr", Parity_Error, 1'b0);
        repeat (15) tick;
        chki("lb_pulses", flag_cnt - f0, 1);
        chk1("lb_sout", Serial_Out, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
